// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: BCD stopwatch core counting MM:SS.hh from a 10 ms tick.
// The count advances once per rising edge of the tick while running. The
// stopwatch drives the upstream timer enable so the timer only runs in RUN.
// Optional lap hold is compiled in with the macro STOPWATCH_LAP_EN.
//
// Handshake: start/stop/clear/lap are single-cycle command strobes sampled
// on every rising clk edge; there is no back-pressure, and priority within a
// cycle is clear > stop > start.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 HALT.

module stopwatch_bcd #(
    parameter bit ROLLOVER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic [23:0] cnt,
    output logic        running,
    output logic        timer_en,
    output logic        wrap,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [23:0] CNT_MAX = 24'h595999;

    state_t      state_q;
    state_t      state_nxt;
    logic        tick_d;
    logic        inc_ev;
    logic        at_max;
    logic [23:0] cnt_q;
    logic [23:0] cnt_nxt;
    logic        wrap_q;
    logic        wrap_nxt;

    // Ripple increment; digits 3 and 5 (seconds tens, minutes tens) stop at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  dig;
        logic [3:0]  lim;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dig = v[i*4 +: 4];
            lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            if (carry) begin
                if (dig == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = dig + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A held tick only counts on its first cycle, and only while running.
    assign inc_ev = tick & ~tick_d & (state_q == S_RUN);
    assign at_max = (cnt_q == CNT_MAX);

    // State register and tick edge-detect flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_d  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tick_d  <= tick;
        end
    end

    // Next-state logic with clear > stop > start priority.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (!clear && !stop && start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (clear)                                  state_nxt = S_IDLE;
                else if (inc_ev && at_max && !ROLLOVER)     state_nxt = S_HALT;
                else if (stop)                              state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (clear)                  state_nxt = S_IDLE;
                else if (!stop && start)    state_nxt = S_RUN;
            end
            S_HALT: begin
                if (clear) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Count datapath: clear beats a coincident increment; end of range
    // either wraps to zero or saturates, and flags wrap in both modes.
    always_comb begin
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        if (clear) begin
            cnt_nxt = 24'h0;
        end else if (inc_ev) begin
            if (at_max) begin
                wrap_nxt = 1'b1;
                cnt_nxt  = ROLLOVER ? 24'h0 : cnt_q;
            end else begin
                cnt_nxt = bcd_inc(cnt_q);
            end
        end
    end

    // Count and wrap registers; cnt_q reloads every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 24'h0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_hold_q;
    logic [23:0] lap_val_q;

    // Lap hold toggles on a lap strobe in RUN and freezes the displayed value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hold_q <= 1'b0;
            lap_val_q  <= 24'h0;
        end else if (clear) begin
            lap_hold_q <= 1'b0;
        end else if (lap && (state_q == S_RUN)) begin
            lap_hold_q <= ~lap_hold_q;
            if (!lap_hold_q) lap_val_q <= cnt_q;
        end
    end
`endif

    // Outputs decoded from registered state only.
    always_comb begin
        running   = (state_q == S_RUN);
        timer_en  = (state_q == S_RUN);
        state_dbg = state_q;
        wrap      = wrap_q;
`ifdef STOPWATCH_LAP_EN
        cnt       = lap_hold_q ? lap_val_q : cnt_q;
`else
        cnt       = cnt_q;
`endif
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed bench for stopwatch_bcd. Two instances share the
// stimulus: dut_r wraps at end of range, dut_s saturates and halts.
// Expected {wrap, running, cnt} values are queued before each step and
// popped once the DUT has produced its response.

module tb_stopwatch_bcd;

    localparam int W = 26;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic lap = 1'b0;
`endif

    logic [23:0] cnt_r, cnt_s;
    logic        running_r, running_s;
    logic        timer_en_r, timer_en_s;
    logic        wrap_r, wrap_s;
    logic [1:0]  state_r, state_s;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] exp_r_q[$];
    logic [W-1:0] exp_s_q[$];
    string        tag_q[$];

    stopwatch_bcd #(.ROLLOVER(1'b1)) dut_r (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .cnt(cnt_r), .running(running_r), .timer_en(timer_en_r), .wrap(wrap_r),
        .state_dbg(state_r)
    );

    stopwatch_bcd #(.ROLLOVER(1'b0)) dut_s (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .cnt(cnt_s), .running(running_s), .timer_en(timer_en_s), .wrap(wrap_s),
        .state_dbg(state_s)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input logic w, input logic r, input logic [23:0] c);
        return {w, r, c};
    endfunction

    task automatic expect_both(input string tag, input logic [W-1:0] er, input logic [W-1:0] es);
        tag_q.push_back(tag);
        exp_r_q.push_back(er);
        exp_s_q.push_back(es);
    endtask

    // Pop one expectation per DUT and compare against the current outputs.
    task automatic check();
        string        t;
        logic [W-1:0] er, es;
        if (tag_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL scoreboard_empty got 0 entries expected 1");
            return;
        end
        t  = tag_q.pop_front();
        er = exp_r_q.pop_front();
        es = exp_s_q.pop_front();
        n_vec++;
        assert ({wrap_r, running_r, cnt_r} === er) else begin
            n_miss++;
            $error("FAIL %s rollover {wrap,run,cnt} got %h expected %h", t, {wrap_r, running_r, cnt_r}, er);
        end
        n_vec++;
        assert ({wrap_s, running_s, cnt_s} === es) else begin
            n_miss++;
            $error("FAIL %s saturate {wrap,run,cnt} got %h expected %h", t, {wrap_s, running_s, cnt_s}, es);
        end
        n_vec++;
        assert ({timer_en_r, timer_en_s} === {er[24], es[24]}) else begin
            n_miss++;
            $error("FAIL %s timer_en got %b expected %b", t, {timer_en_r, timer_en_s}, {er[24], es[24]});
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] er, input logic [1:0] es);
        n_vec++;
        assert ({state_r, state_s} === {er, es}) else begin
            n_miss++;
            $error("FAIL %s state got %h/%h expected %h/%h", tag, state_r, state_s, er, es);
        end
    endtask

    // One clock of stimulus; command strobes drop after the edge, tick persists.
    task automatic cycle(input logic st, input logic sp, input logic cl, input logic tk);
        @(negedge clk);
        start = st;
        stop  = sp;
        clear = cl;
        tick  = tk;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic lap_cycle();
        @(negedge clk);
        lap = 1'b1;
        @(posedge clk);
        #1;
        lap = 1'b0;
    endtask
`endif

    initial begin
        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_both("reset", pk(1'b0, 1'b0, 24'h0), pk(1'b0, 1'b0, 24'h0));
        check();
        check_state("reset", 2'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic count, pause, resume
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_both("start", pk(1'b0, 1'b1, 24'h0), pk(1'b0, 1'b1, 24'h0));
        check();
        tick_n(100);
        expect_both("count_100", pk(1'b0, 1'b1, 24'h000100), pk(1'b0, 1'b1, 24'h000100));
        check();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(5);
        expect_both("paused_ticks", pk(1'b0, 1'b0, 24'h000100), pk(1'b0, 1'b0, 24'h000100));
        check();
        check_state("paused", 2'd2, 2'd2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(1);
        expect_both("resume_101", pk(1'b0, 1'b1, 24'h000101), pk(1'b0, 1'b1, 24'h000101));
        check();

        // Carries and held tick
        tick_n(5898);
        expect_both("count_5999", pk(1'b0, 1'b1, 24'h005999), pk(1'b0, 1'b1, 24'h005999));
        check();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        expect_both("held_tick", pk(1'b0, 1'b1, 24'h010000), pk(1'b0, 1'b1, 24'h010000));
        check();

        // Priority
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_both("clear_run", pk(1'b0, 1'b0, 24'h0), pk(1'b0, 1'b0, 24'h0));
        check();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(9);
        expect_both("count_9", pk(1'b0, 1'b1, 24'h000009), pk(1'b0, 1'b1, 24'h000009));
        check();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        expect_both("stop_tick", pk(1'b0, 1'b0, 24'h000010), pk(1'b0, 1'b0, 24'h000010));
        check();
        check_state("stop_tick", 2'd2, 2'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        tick_n(2);
        expect_both("pause_hold", pk(1'b0, 1'b0, 24'h000010), pk(1'b0, 1'b0, 24'h000010));
        check();
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        expect_both("clr_stop_start", pk(1'b0, 1'b0, 24'h0), pk(1'b0, 1'b0, 24'h0));
        check();
        check_state("clr_stop_start", 2'd0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        expect_both("start_tick", pk(1'b0, 1'b1, 24'h0), pk(1'b0, 1'b1, 24'h0));
        check();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        expect_both("start_tick_after", pk(1'b0, 1'b1, 24'h0), pk(1'b0, 1'b1, 24'h0));
        check();

        // Asynchronous reset mid-run
        tick_n(512);
        expect_both("count_512", pk(1'b0, 1'b1, 24'h000512), pk(1'b0, 1'b1, 24'h000512));
        check();
        #2;
        rst = 1'b1;
        #1;
        expect_both("async_reset", pk(1'b0, 1'b0, 24'h0), pk(1'b0, 1'b0, 24'h0));
        check();
        @(negedge clk);
        rst = 1'b0;

`ifdef STOPWATCH_LAP_EN
        // Lap hold
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(200);
        lap_cycle();
        expect_both("lap_capture", pk(1'b0, 1'b1, 24'h000200), pk(1'b0, 1'b1, 24'h000200));
        check();
        tick_n(50);
        expect_both("lap_hold", pk(1'b0, 1'b1, 24'h000200), pk(1'b0, 1'b1, 24'h000200));
        check();
        lap_cycle();
        expect_both("lap_release", pk(1'b0, 1'b1, 24'h000250), pk(1'b0, 1'b1, 24'h000250));
        check();
        lap_cycle();
        tick_n(3);
        expect_both("lap_hold2", pk(1'b0, 1'b1, 24'h000250), pk(1'b0, 1'b1, 24'h000250));
        check();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_both("lap_clear", pk(1'b0, 1'b0, 24'h0), pk(1'b0, 1'b0, 24'h0));
        check();
`endif

        // End of range: preload near the top of the range
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        force dut_r.cnt_q = 24'h595998;
        force dut_s.cnt_q = 24'h595998;
        @(posedge clk);
        #1;
        release dut_r.cnt_q;
        release dut_s.cnt_q;
        expect_both("preload", pk(1'b0, 1'b1, 24'h595998), pk(1'b0, 1'b1, 24'h595998));
        check();
        tick_n(1);
        expect_both("count_max", pk(1'b0, 1'b1, 24'h595999), pk(1'b0, 1'b1, 24'h595999));
        check();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        expect_both("end_edge", pk(1'b1, 1'b1, 24'h0), pk(1'b1, 1'b0, 24'h595999));
        check();
        check_state("end_edge", 2'd1, 2'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        expect_both("wrap_one_cycle", pk(1'b0, 1'b1, 24'h0), pk(1'b0, 1'b0, 24'h595999));
        check();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_both("halt_start", pk(1'b0, 1'b1, 24'h0), pk(1'b0, 1'b0, 24'h595999));
        check();
        check_state("halt_start", 2'd1, 2'd3);
        tick_n(1);
        expect_both("halt_tick", pk(1'b0, 1'b1, 24'h000001), pk(1'b0, 1'b0, 24'h595999));
        check();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        expect_both("halt_stop", pk(1'b0, 1'b0, 24'h000001), pk(1'b0, 1'b0, 24'h595999));
        check();
        check_state("halt_stop", 2'd2, 2'd3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_both("halt_clear", pk(1'b0, 1'b0, 24'h0), pk(1'b0, 1'b0, 24'h0));
        check();
        check_state("halt_clear", 2'd0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
